// File: rtl/tile_control_unit_pkg.sv
// Shared constants for the tiled TPU controller: default array size,
// compute/loader FSM state encodings and tile-count helpers.
package tpu_package;

    localparam int DEF_MUL_SIZE = 8;

    // Compute FSM states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT_W  = 3'd1;
    localparam logic [2:0] ST_COMPUTE = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // Weight loader FSM states
    localparam logic [0:0] LD_IDLE = 1'b0;
    localparam logic [0:0] LD_LOAD = 1'b1;

    function automatic logic [15:0] ceil_div(input logic [15:0] num, input logic [15:0] den);
        return (num + den - 16'd1) / den;
    endfunction

    // Number of MUL_SIZE-row weight tiles needed to cover an inner dimension.
    function automatic logic [15:0] tile_count(input logic [15:0] w_dim, input int mul_size);
        return ceil_div(w_dim, 16'(mul_size));
    endfunction

endpackage

// File: rtl/tile_control_unit_acc_write_pipe.sv
// Fixed-latency delay line carrying accumulator write requests from
// activation issue to the accumulator write port. Needs LAT >= 2.
module acc_write_pipe
    import tpu_package::*;
#(
    parameter int LAT    = 16,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              push_add,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_add,
    output logic              empty,
    output logic              empty_next
);

    logic [LAT-1:0]    valid_reg;
    logic [LAT-1:0]    add_reg;
    logic [ADDR_W-1:0] addr_reg [LAT];

    // Shift every stage one step per cycle; stage 0 captures the new request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
            add_reg   <= '0;
            for (int k = 0; k < LAT; k++) begin
                addr_reg[k] <= '0;
            end
        end else begin
            valid_reg   <= {valid_reg[LAT-2:0], push_valid};
            add_reg     <= {add_reg[LAT-2:0], push_add};
            addr_reg[0] <= push_addr;
            for (int k = 1; k < LAT; k++) begin
                addr_reg[k] <= addr_reg[k-1];
            end
        end
    end

    // Outputs are forced to zero when the head stage holds no request.
    assign out_valid  = valid_reg[LAT-1];
    assign out_addr   = valid_reg[LAT-1] ? addr_reg[LAT-1] : '0;
    assign out_add    = valid_reg[LAT-1] & add_reg[LAT-1];
    assign empty      = ~|valid_reg;
    // Only the head stage (if anything) is occupied: empty after this cycle.
    assign empty_next = ~|valid_reg[LAT-2:0];

endmodule

// File: rtl/tile_control_unit.sv
// Multi-tile matrix-multiply sequencer: ping-pongs two weight banks,
// prefetching the next tile while the current one computes, streams
// activations and steers delayed accumulator writes.
module tile_control_unit
    import tpu_package::*;
#(
    parameter int MUL_SIZE  = DEF_MUL_SIZE,
    parameter int ACC_DEPTH = 128,
    parameter int ACC_LAT   = 2 * MUL_SIZE,
    parameter int DIM_W     = 9,
    parameter int UB_ADDR_W = 12
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         instruction_i,
    input  logic [DIM_W-1:0]             H_DIM_i,
    input  logic [DIM_W-1:0]             W_DIM_i,
    input  logic [UB_ADDR_W-1:0]         unified_buffer_start_addr_rd_i,
    input  logic                         weight_fifo_valid_output,
    output logic                         load_weights_o,
    output logic                         weight_bank_sel_o,
    output logic [UB_ADDR_W-1:0]         unified_buffer_addr_rd_o,
    output logic                         load_activations_o,
    output logic                         MAC_compute_o,
    output logic                         stall_compute_o,
    output logic                         write_accumulator_o,
    output logic                         accumulator_add_o,
    output logic [$clog2(ACC_DEPTH)-1:0] accumulator_addr_wr_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         error_o
);

    localparam int ROW_W = $clog2(ACC_DEPTH);
    localparam int CNT_W = (MUL_SIZE > 1) ? $clog2(MUL_SIZE) : 1;

    logic [2:0]           state_reg;
    logic [0:0]           ld_state_reg;
    logic [DIM_W-1:0]     h_dim_reg;
    logic [DIM_W-1:0]     tiles_reg;
    logic [DIM_W-1:0]     tile_reg;
    logic [DIM_W-1:0]     tiles_loaded_reg;
    logic [DIM_W-1:0]     issue_idx_reg;
    logic [CNT_W-1:0]     row_cnt_reg;
    logic                 shadow_full_reg;
    logic                 bank_sel_reg;
    logic                 error_reg;
    logic [UB_ADDR_W-1:0] addr_reg;

    logic dims_bad;
    logic accept;
    logic pop;
    logic swap;
    logic computing;
    logic last_issue;
    logic last_tile;
    logic last_row;
    logic pipe_empty;
    logic pipe_empty_next;

    assign dims_bad   = (H_DIM_i == '0) || (W_DIM_i == '0) || (int'(H_DIM_i) > ACC_DEPTH);
    assign accept     = (state_reg == ST_IDLE) && instruction_i && !dims_bad;
    assign computing  = (state_reg == ST_COMPUTE);
    assign swap       = (state_reg == ST_WAIT_W) && shadow_full_reg;
    assign last_issue = (issue_idx_reg == h_dim_reg - DIM_W'(1));
    assign last_tile  = (tile_reg + DIM_W'(1) == tiles_reg);
    assign last_row   = (row_cnt_reg == CNT_W'(MUL_SIZE - 1));
    // A row is popped straight off a valid FIFO head whenever the shadow bank
    // has room and tiles remain to be fetched.
    assign pop        = (ld_state_reg == LD_LOAD) && weight_fifo_valid_output &&
                        !shadow_full_reg && (tiles_loaded_reg < tiles_reg);

    // Compute sequencer: accept/validate, wait for weights, issue activations, drain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            h_dim_reg     <= '0;
            tiles_reg     <= '0;
            tile_reg      <= '0;
            issue_idx_reg <= '0;
            addr_reg      <= '0;
            bank_sel_reg  <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            error_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (instruction_i) begin
                        if (dims_bad) begin
                            error_reg <= 1'b1;
                        end else begin
                            h_dim_reg     <= H_DIM_i;
                            tiles_reg     <= DIM_W'(tile_count(16'(W_DIM_i), MUL_SIZE));
                            tile_reg      <= '0;
                            issue_idx_reg <= '0;
                            addr_reg      <= unified_buffer_start_addr_rd_i;
                            state_reg     <= ST_WAIT_W;
                        end
                    end
                end
                ST_WAIT_W: begin
                    if (shadow_full_reg) begin
                        bank_sel_reg <= ~bank_sel_reg;
                        state_reg    <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    // Activation rows are contiguous across tiles, so one
                    // running address covers base + t*H + i.
                    addr_reg <= addr_reg + UB_ADDR_W'(1);
                    if (last_issue) begin
                        issue_idx_reg <= '0;
                        tile_reg      <= tile_reg + DIM_W'(1);
                        state_reg     <= last_tile ? ST_DRAIN : ST_WAIT_W;
                    end else begin
                        issue_idx_reg <= issue_idx_reg + DIM_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (pipe_empty || pipe_empty_next) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Weight loader: fills the shadow bank one row per valid FIFO cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ld_state_reg     <= LD_IDLE;
            row_cnt_reg      <= '0;
            tiles_loaded_reg <= '0;
            shadow_full_reg  <= 1'b0;
        end else if (ld_state_reg == LD_IDLE) begin
            if (accept) begin
                ld_state_reg     <= LD_LOAD;
                row_cnt_reg      <= '0;
                tiles_loaded_reg <= '0;
                shadow_full_reg  <= 1'b0;
            end
        end else begin
            if (state_reg == ST_DONE) begin
                ld_state_reg <= LD_IDLE;
            end
            if (pop) begin
                if (last_row) begin
                    row_cnt_reg      <= '0;
                    shadow_full_reg  <= 1'b1;
                    tiles_loaded_reg <= tiles_loaded_reg + DIM_W'(1);
                end else begin
                    row_cnt_reg <= row_cnt_reg + CNT_W'(1);
                end
            end else if (swap) begin
                shadow_full_reg <= 1'b0;
            end
        end
    end

    acc_write_pipe #(
        .LAT    (ACC_LAT),
        .ADDR_W (ROW_W)
    ) u_acc_write_pipe (
        .clk        (clk_i),
        .rst        (rst_i),
        .push_valid (computing),
        .push_addr  (ROW_W'(issue_idx_reg)),
        .push_add   (tile_reg != '0),
        .out_valid  (write_accumulator_o),
        .out_addr   (accumulator_addr_wr_o),
        .out_add    (accumulator_add_o),
        .empty      (pipe_empty),
        .empty_next (pipe_empty_next)
    );

    assign load_weights_o           = pop;
    assign weight_bank_sel_o        = bank_sel_reg;
    assign load_activations_o       = computing;
    assign MAC_compute_o            = computing;
    assign unified_buffer_addr_rd_o = computing ? addr_reg : '0;
    assign stall_compute_o          = (state_reg == ST_WAIT_W);
    assign busy_o                   = (state_reg != ST_IDLE);
    assign done_o                   = (state_reg == ST_DONE);
    assign error_o                  = error_reg;

endmodule
